// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: encoder command encodings, symbol timing and serializer states.
package ws2812_pkg;

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_TX    = 2'b01;
  localparam logic [1:0] CMD_RESET = 2'b10;

  localparam int SYMBOL_PERIOD_NS  = 1250;
  // 40 symbols of 1.25 us give the 50 us low time the LEDs need to latch
  localparam int MIN_RESET_SYMBOLS = 40;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_STARVE,
    ST_LATCH
  } state_e;

endpackage

// File: rtl/ws2812_latch_timer.sv
// Loadable down-counter advanced by symbol ticks; done_o is high while the count sits at zero.
module ws2812_latch_timer #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             tick_i,
  output logic             done_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (tick_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/ws2812_pixel_serializer.sv
// Streams pixels MSB-first into look-ahead encoder commands and appends the latch period per frame.
// Define WS2812_RGB_REORDER_EN to accept {R,G,B} pixels and reorder them to {G,R,B} at load.
module ws2812_pixel_serializer
  import ws2812_pkg::*;
#(
  parameter int PIXEL_BITS    = 24,
  parameter int RESET_SYMBOLS = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PIXEL_BITS-1:0] pix_data,
  input  logic                  pix_valid,
  input  logic                  pix_last,
  output logic                  pix_ready,
  output logic [1:0]            cmd,
  output logic                  databit,
  input  logic                  cmd_req,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  underrun
);

  localparam int BW = $clog2(PIXEL_BITS);
  localparam int LW = $clog2(RESET_SYMBOLS);

  if (RESET_SYMBOLS < MIN_RESET_SYMBOLS) begin : g_bad_reset_symbols
    $error("RESET_SYMBOLS must be at least %0d", MIN_RESET_SYMBOLS);
  end

  state_e                state_q;
  logic [PIXEL_BITS-1:0] shift_q;
  logic [BW-1:0]         bit_cnt_q;
  logic                  last_q;
  logic [1:0]            cmd_q;
  logic                  databit_q;
  logic                  rdy_q;
  logic                  busy_q;
  logic                  frame_done_q;
  logic                  underrun_q;

  logic [PIXEL_BITS-1:0] load_data;
  logic                  last_bit;
  logic                  reload_ready;
  logic                  accept;
  logic                  latch_load;
  logic                  latch_tick;
  logic                  latch_done;

`ifdef WS2812_RGB_REORDER_EN
  if (PIXEL_BITS != 24) begin : g_bad_reorder_width
    $error("WS2812_RGB_REORDER_EN requires PIXEL_BITS == 24");
  end
  assign load_data = {pix_data[15:8], pix_data[23:16], pix_data[7:0]};
`else
  assign load_data = pix_data;
`endif

  assign last_bit = (bit_cnt_q == '0);

  // Zero-bubble reload: the next pixel is taken on the same edge that consumes the last bit
  assign reload_ready = (state_q == ST_SHIFT) && cmd_req && last_bit && !last_q && !rst;
  assign pix_ready    = rdy_q | reload_ready;
  assign accept       = pix_valid && pix_ready;

  assign latch_load = (state_q == ST_SHIFT) && cmd_req && last_bit && last_q && !rst;
  assign latch_tick = (state_q == ST_LATCH) && cmd_req && !rst;

  ws2812_latch_timer #(
    .WIDTH (LW)
  ) u_latch_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (latch_load),
    .load_val_i (LW'(RESET_SYMBOLS - 1)),
    .tick_i     (latch_tick),
    .done_o     (latch_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      last_q       <= 1'b0;
      cmd_q        <= CMD_IDLE;
      databit_q    <= 1'b0;
      rdy_q        <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
      case (state_q)
        ST_IDLE, ST_STARVE: begin
          rdy_q <= 1'b1;
          cmd_q <= CMD_IDLE;
          if (accept) begin
            shift_q   <= load_data;
            bit_cnt_q <= BW'(PIXEL_BITS - 1);
            last_q    <= pix_last;
            cmd_q     <= CMD_TX;
            databit_q <= load_data[PIXEL_BITS-1];
            rdy_q     <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cmd_req) begin
            if (!last_bit) begin
              shift_q   <= shift_q << 1;
              bit_cnt_q <= bit_cnt_q - BW'(1);
              databit_q <= shift_q[PIXEL_BITS-2];
            end else if (last_q) begin
              cmd_q     <= CMD_RESET;
              databit_q <= 1'b0;
              state_q   <= ST_LATCH;
            end else if (accept) begin
              shift_q   <= load_data;
              bit_cnt_q <= BW'(PIXEL_BITS - 1);
              last_q    <= pix_last;
              databit_q <= load_data[PIXEL_BITS-1];
            end else begin
              cmd_q      <= CMD_IDLE;
              databit_q  <= 1'b0;
              rdy_q      <= 1'b1;
              underrun_q <= 1'b1;
              state_q    <= ST_STARVE;
            end
          end
        end
        ST_LATCH: begin
          if (cmd_req && latch_done) begin
            cmd_q        <= CMD_IDLE;
            rdy_q        <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd        = cmd_q;
  assign databit    = databit_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_ws2812_pixel_serializer.sv
// Scoreboard bench for ws2812_pixel_serializer: expected bits are queued at pixel accept and popped on consumed TX slots.
module tb_ws2812_pixel_serializer;
  import ws2812_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        pix_last;
  logic        pix_ready;
  logic [1:0]  cmd;
  logic        databit;
  logic        cmd_req;
  logic        busy;
  logic        frame_done;
  logic        underrun;

  typedef struct {
    logic [23:0] data;
    logic        last;
  } pixel_t;

  int     testsRun = 0;
  int     testsFailed = 0;
  bit     expBits[$];
  pixel_t pendQ[$];
  int     txCnt, resetCnt, idleCnt, frameIdle, slotIdx, firstTx, lastTx;
  int     acceptedCnt, reloadOnLast, holdSlots;
  int     fdCnt = 0;
  int     urCnt = 0;
  int     fdStart, urStart;
  logic [23:0] rxWord;

  ws2812_pixel_serializer #(
    .PIXEL_BITS    (24),
    .RESET_SYMBOLS (64)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_last   (pix_last),
    .pix_ready  (pix_ready),
    .cmd        (cmd),
    .databit    (databit),
    .cmd_req    (cmd_req),
    .busy       (busy),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle, well after the registered outputs settle
  always @(posedge clk) begin
    #2;
    if (frame_done === 1'b1) fdCnt++;
    if (underrun === 1'b1) urCnt++;
  end

  function automatic logic [23:0] expOrder(input logic [23:0] d);
`ifdef WS2812_RGB_REORDER_EN
    return {d[15:8], d[23:16], d[7:0]};
`else
    return d;
`endif
  endfunction

  task automatic clearCounters();
    txCnt = 0; resetCnt = 0; idleCnt = 0; frameIdle = 0; slotIdx = 0;
    firstTx = 0; lastTx = 0; acceptedCnt = 0; reloadOnLast = 0; rxWord = '0;
    fdStart = fdCnt; urStart = urCnt;
  endtask

  task automatic presentNext();
    pixel_t p;
    p = pendQ.pop_front();
    pix_data  = p.data;
    pix_last  = p.last;
    pix_valid = 1'b1;
  endtask

  // One clock of the encoder model; inputs change at the falling edge
  task automatic tick(input logic req);
    logic [1:0]  c;
    logic        b;
    logic        acc;
    int          remaining;
    logic [23:0] ord;
    cmd_req = req;
    #1;
    c = cmd; b = databit; acc = pix_valid & pix_ready; remaining = expBits.size();
    @(negedge clk);
    cmd_req = 1'b0;
    if (req) begin
      slotIdx++;
      case (c)
        CMD_TX: begin
          testsRun++;
          if (expBits.size() == 0) begin
            testsFailed++;
            $display("[TB] FAIL tx_unexpected: got TX slot with databit=%0b, required no TX slot", b);
          end else begin
            bit e;
            e = expBits.pop_front();
            if (b !== e) begin
              testsFailed++;
              $display("[TB] FAIL databit slot %0d: got %0b, required %0b", slotIdx, b, e);
            end
          end
          if (txCnt == 0) firstTx = slotIdx;
          lastTx = slotIdx;
          txCnt++;
          rxWord = {rxWord[22:0], b};
        end
        CMD_RESET: resetCnt++;
        CMD_IDLE: begin
          idleCnt++;
          if (txCnt > 0 && resetCnt == 0) frameIdle++;
        end
        default: begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL cmd_encoding: got %0b, required a defined command", c);
        end
      endcase
    end
    if (acc) begin
      if (req && c == CMD_TX && remaining == 1) reloadOnLast++;
      ord = expOrder(pix_data);
      for (int i = 23; i >= 0; i--) expBits.push_back(ord[i]);
      acceptedCnt++;
      pix_valid = 1'b0;
    end
    if (!pix_valid && pendQ.size() > 0 && (acceptedCnt == 0 || frameIdle >= holdSlots))
      presentNext();
  endtask

  task automatic runFrame(input int period, input int hold, input int budget);
    bit done;
    done = 0;
    clearCounters();
    holdSlots = hold;
    if (pendQ.size() > 0) presentNext();
    for (int i = 0; i < budget && !done; i++) begin
      tick((i % period) == period - 1);
      if (fdCnt != fdStart) done = 1;
    end
    repeat (3) tick(1'b0);
    testsRun++;
    if (!done) begin
      testsFailed++;
      $display("[TB] FAIL frame_timeout: got no frame_done in %0d cycles, required one", budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_req = 1'b1;
    repeat (2) @(negedge clk);
    testsRun += 6;
    if (cmd !== CMD_IDLE) begin testsFailed++; $display("[TB] FAIL reset_cmd: got %0b, required %0b", cmd, CMD_IDLE); end
    if (databit !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_databit: got %0b, required 0", databit); end
    if (pix_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_pix_ready: got %0b, required 0", pix_ready); end
    if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy: got %0b, required 0", busy); end
    if (frame_done !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_frame_done: got %0b, required 0", frame_done); end
    if (underrun !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_underrun: got %0b, required 0", underrun); end
    rst = 1'b0; cmd_req = 1'b0;
    @(negedge clk);
    testsRun += 2;
    if (pix_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL idle_pix_ready: got %0b, required 1", pix_ready); end
    if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL idle_busy: got %0b, required 0", busy); end
  endtask

  task automatic test_single_pixel();
    pendQ.push_back('{24'hA50FC3, 1'b1});
    runFrame(12, 0, 2000);
    testsRun += 6;
    if (txCnt !== 24) begin testsFailed++; $display("[TB] FAIL single_tx_count: got %0d, required 24", txCnt); end
    if (resetCnt !== 64) begin testsFailed++; $display("[TB] FAIL single_reset_slots: got %0d, required 64", resetCnt); end
    if (expBits.size() !== 0) begin testsFailed++; $display("[TB] FAIL single_bits_left: got %0d, required 0", expBits.size()); end
    if (fdCnt - fdStart !== 1) begin testsFailed++; $display("[TB] FAIL single_frame_done: got %0d pulses, required 1", fdCnt - fdStart); end
    if (urCnt - urStart !== 0) begin testsFailed++; $display("[TB] FAIL single_underrun: got %0d pulses, required 0", urCnt - urStart); end
    if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_busy_end: got %0b, required 0", busy); end
  endtask

  task automatic test_back_to_back();
    pendQ.push_back('{24'hFFFFFF, 1'b0});
    pendQ.push_back('{24'h000000, 1'b1});
    runFrame(4, 0, 1500);
    testsRun += 6;
    if (reloadOnLast !== 1) begin testsFailed++; $display("[TB] FAIL b2b_reload_on_bit0: got %0d, required 1", reloadOnLast); end
    if (txCnt !== 48) begin testsFailed++; $display("[TB] FAIL b2b_tx_count: got %0d, required 48", txCnt); end
    if (lastTx - firstTx + 1 !== 48) begin testsFailed++; $display("[TB] FAIL b2b_contiguous: got span %0d, required 48", lastTx - firstTx + 1); end
    if (frameIdle !== 0) begin testsFailed++; $display("[TB] FAIL b2b_idle_slots: got %0d, required 0", frameIdle); end
    if (urCnt - urStart !== 0) begin testsFailed++; $display("[TB] FAIL b2b_underrun: got %0d pulses, required 0", urCnt - urStart); end
    if (fdCnt - fdStart !== 1) begin testsFailed++; $display("[TB] FAIL b2b_frame_done: got %0d pulses, required 1", fdCnt - fdStart); end
  endtask

  task automatic test_underrun();
    pendQ.push_back('{24'h123456, 1'b0});
    pendQ.push_back('{24'h800001, 1'b1});
    runFrame(4, 5, 1500);
    testsRun += 5;
    if (urCnt - urStart !== 1) begin testsFailed++; $display("[TB] FAIL starve_underrun: got %0d pulses, required 1", urCnt - urStart); end
    if (frameIdle !== 5) begin testsFailed++; $display("[TB] FAIL starve_idle_slots: got %0d, required 5", frameIdle); end
    if (txCnt !== 48) begin testsFailed++; $display("[TB] FAIL starve_tx_count: got %0d, required 48", txCnt); end
    if (resetCnt !== 64) begin testsFailed++; $display("[TB] FAIL starve_reset_slots: got %0d, required 64", resetCnt); end
    if (fdCnt - fdStart !== 1) begin testsFailed++; $display("[TB] FAIL starve_frame_done: got %0d pulses, required 1", fdCnt - fdStart); end
  endtask

  task automatic test_reset_mid_frame();
    int guard;
    clearCounters();
    holdSlots = 0;
    pendQ.push_back('{24'hFFFFFF, 1'b1});
    presentNext();
    guard = 0;
    while (txCnt < 10 && guard < 500) begin
      tick((guard % 4) == 3);
      guard++;
    end
    testsRun++;
    if (txCnt !== 10) begin testsFailed++; $display("[TB] FAIL midrst_progress: got %0d bits, required 10", txCnt); end
    rst = 1'b1; cmd_req = 1'b1;
    @(negedge clk);
    testsRun += 3;
    if (cmd !== CMD_IDLE) begin testsFailed++; $display("[TB] FAIL midrst_cmd: got %0b, required %0b", cmd, CMD_IDLE); end
    if (pix_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL midrst_pix_ready: got %0b, required 0", pix_ready); end
    if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL midrst_busy: got %0b, required 0", busy); end
    @(negedge clk);
    rst = 1'b0; cmd_req = 1'b0;
    expBits.delete();
    clearCounters();
    for (int i = 0; i < 80; i++) tick((i % 4) == 3);
    testsRun += 2;
    if (fdCnt - fdStart !== 0) begin testsFailed++; $display("[TB] FAIL midrst_frame_done: got %0d pulses, required 0", fdCnt - fdStart); end
    if (idleCnt !== 20) begin testsFailed++; $display("[TB] FAIL midrst_idle_slots: got %0d, required 20", idleCnt); end
    pendQ.push_back('{24'h3C6996, 1'b1});
    runFrame(4, 0, 1500);
    testsRun += 2;
    if (rxWord !== 24'h3C6996) begin testsFailed++; $display("[TB] FAIL midrst_new_pixel: got %h, required 3c6996", rxWord); end
    if (txCnt !== 24) begin testsFailed++; $display("[TB] FAIL midrst_tx_count: got %0d, required 24", txCnt); end
  endtask

  task automatic test_reorder();
    logic [23:0] want;
`ifdef WS2812_RGB_REORDER_EN
    want = 24'h221133;
`else
    want = 24'h112233;
`endif
    pendQ.push_back('{24'h112233, 1'b1});
    runFrame(4, 0, 1500);
    testsRun += 2;
    if (rxWord !== want) begin testsFailed++; $display("[TB] FAIL reorder_word: got %h, required %h", rxWord, want); end
    if (txCnt !== 24) begin testsFailed++; $display("[TB] FAIL reorder_tx_count: got %0d, required 24", txCnt); end
  endtask

  task automatic test_idle_creq();
    clearCounters();
    for (int i = 0; i < 20; i++) tick(1'b1);
    repeat (2) tick(1'b0);
    testsRun += 5;
    if (idleCnt !== 20) begin testsFailed++; $display("[TB] FAIL idlereq_idle_slots: got %0d, required 20", idleCnt); end
    if (fdCnt - fdStart !== 0) begin testsFailed++; $display("[TB] FAIL idlereq_frame_done: got %0d pulses, required 0", fdCnt - fdStart); end
    if (urCnt - urStart !== 0) begin testsFailed++; $display("[TB] FAIL idlereq_underrun: got %0d pulses, required 0", urCnt - urStart); end
    if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL idlereq_busy: got %0b, required 0", busy); end
    if (pix_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL idlereq_pix_ready: got %0b, required 1", pix_ready); end
  endtask

  initial begin
    rst = 1'b1; cmd_req = 1'b0; pix_valid = 1'b0; pix_last = 1'b0; pix_data = '0;
    holdSlots = 0;
    clearCounters();
    @(negedge clk);
    test_reset();
    test_single_pixel();
    test_back_to_back();
    test_underrun();
    test_reset_mid_frame();
    test_reorder();
    test_idle_creq();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
